// File: rtl/memory_access_controller.sv
// -----------------------------------------------------------------------------
// memory_access_controller
//
// Purpose:
//   Bridges the data register controller and the external memory bus. One
//   request (read or write) is accepted while idle; it is driven onto the bus
//   with a req/ack handshake. Read data is returned on a registered bus that
//   feeds the register file. A completed instruction fetch pulses the program
//   counter count enable together with the completion pulse.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   When defined, an access that sees no ack for TIMEOUT cycles is abandoned.
//   In that case o_err and o_done pulse together, o_pc_count_en stays low and
//   o_rdata is left untouched. When undefined, ACCESS waits for ack forever
//   and o_err is constant 0.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   i_rd_start     read request, sampled only in IDLE
//   i_wr_start     write request, sampled only in IDLE (wins over read)
//   i_fetch        marks a read as an instruction fetch, sampled with start
//   i_addr         address, captured at start (LSBs drive the bus)
//   i_wdata        write data, captured at start
//   o_busy         high while a transaction is in ACCESS or DONE
//   o_done         one-cycle completion pulse
//   o_rdata        last read data, held until the next read completes
//   o_pc_count_en  one-cycle pulse with o_done for a completed fetch
//   o_mem_req      bus request
//   o_mem_we       bus direction, 1 = write (valid while o_mem_req)
//   o_mem_addr     bus address (stable while o_mem_req)
//   o_mem_wdata    bus write data (stable while o_mem_req)
//   i_mem_ack      bus acknowledge, only looked at in ACCESS
//   i_mem_rdata    bus read data, valid in the ack cycle
//   o_err          timeout pulse (constant 0 without MEM_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module memory_access_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_start,
  input  logic                  i_wr_start,
  input  logic                  i_fetch,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_pc_count_en,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;

  // Per-transaction context captured at start
  logic                    we_r;
  logic                    fetch_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;

  // Registered outputs
  logic                    busy_r;
  logic                    done_r;
  logic                    req_r;
  logic                    pc_count_en_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  // Decoded events for the current cycle
  logic                    capture_s;
  logic                    ack_hit_s;
  logic                    timeout_s;
  logic                    timeout_hit_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]        wait_cnt_r;

  // The counter holds the number of ack-less ACCESS cycles already elapsed,
  // so the TIMEOUT-th such cycle is the one where it still reads TIMEOUT-1.
  assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));

  // Wait counter: cleared when a transaction is accepted, counts ACCESS
  // cycles that pass without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (capture_s) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !i_mem_ack) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  // No timeout in this build; TIMEOUT is a positive count, so this folds to 0.
  assign timeout_s = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  // Next-state decode and per-cycle events. Ack takes priority over timeout.
  always_comb begin
    state_next_s  = state_r;
    capture_s     = 1'b0;
    ack_hit_s     = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_rd_start || i_wr_start) begin
          state_next_s = ST_ACCESS;
          capture_s    = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (i_mem_ack) begin
          state_next_s = ST_DONE;
          ack_hit_s    = 1'b1;
        end else if (timeout_s) begin
          state_next_s  = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Transaction context: captured once at start and held for the whole
  // transaction so the bus sees stable address/data/direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      fetch_r <= 1'b0;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (capture_s) begin
      we_r    <= i_wr_start;
      fetch_r <= i_fetch & ~i_wr_start;
      addr_r  <= i_addr[ADDR_WIDTH-1:0];
      wdata_r <= i_wdata;
    end else begin
      we_r    <= we_r;
      fetch_r <= fetch_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Status and handshake outputs, registered from the next state so each one
  // lines up with the state it describes without a combinational output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r        <= 1'b0;
      req_r         <= 1'b0;
      done_r        <= 1'b0;
      pc_count_en_r <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      busy_r        <= (state_next_s != ST_IDLE);
      req_r         <= (state_next_s == ST_ACCESS);
      done_r        <= (state_next_s == ST_DONE);
      pc_count_en_r <= ack_hit_s & fetch_r;
      err_r         <= timeout_hit_s;
    end
  end

  // Read data return: only a successfully acknowledged read updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (ack_hit_s && !we_r) begin
      rdata_r <= i_mem_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_rdata       = rdata_r;
  assign o_pc_count_en = pc_count_en_r;
  assign o_mem_req     = req_r;
  assign o_mem_we      = we_r;
  assign o_mem_addr    = addr_r;
  assign o_mem_wdata   = wdata_r;
  assign o_err         = err_r;

endmodule

// File: tb/tb_memory_access_controller.sv
module tb_memory_access_controller;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_rd_start = 1'b0;
  logic          i_wr_start = 1'b0;
  logic          i_fetch = 1'b0;
  logic [DW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic          o_busy;
  logic          o_done;
  logic [DW-1:0] o_rdata;
  logic          o_pc_count_en;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ack = 1'b0;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          o_err;

  memory_access_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_start(i_rd_start), .i_wr_start(i_wr_start), .i_fetch(i_fetch),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_pc_count_en(o_pc_count_en),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int total = 0;
  int bad = 0;

  // Reference model state: what o_rdata must hold after the last transaction
  logic [DW-1:0] exp_rdata = '0;

  // Observations gathered by do_txn for one transaction
  int            obs_req, obs_busy, obs_done, obs_pc, obs_err, obs_done_cyc, obs_first_req, obs_start_edge;
  logic          obs_we, obs_unstable;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one transaction and act as the bus responder: ack on the k-th
  // request cycle (k = 0 never acks). With noisy set, extra starts and stray
  // acks outside ACCESS are thrown at the DUT while it is busy.
  task automatic do_txn(input logic rd, input logic wr, input logic fet,
                        input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int k, input bit noisy);
    obs_req = 0; obs_busy = 0; obs_done = 0; obs_pc = 0; obs_err = 0;
    obs_done_cyc = -1; obs_first_req = -1; obs_unstable = 1'b0;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
    i_rd_start = rd; i_wr_start = wr; i_fetch = fet; i_addr = addr; i_wdata = wdata;
    i_mem_ack = 1'b0;
    step();
    obs_start_edge = edge_cnt;
    i_rd_start = 1'b0; i_wr_start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (o_mem_req) begin
        if (obs_first_req < 0) begin
          obs_first_req = c; obs_addr = o_mem_addr; obs_we = o_mem_we; obs_wdata = o_mem_wdata;
        end else if (o_mem_addr !== obs_addr || o_mem_we !== obs_we || o_mem_wdata !== obs_wdata) begin
          obs_unstable = 1'b1;
        end
        obs_req++;
      end
      if (o_busy) obs_busy++;
      if (o_done) begin
        obs_done++;
        if (obs_done_cyc < 0) obs_done_cyc = c;
      end
      if (o_pc_count_en) obs_pc++;
      if (o_err) obs_err++;
      if (obs_done > 0 && !o_done) break;
      i_mem_ack   = o_mem_req && (obs_req == k);
      i_mem_rdata = i_mem_ack ? rdata : DW'($urandom);
      if (noisy && o_busy) begin
        i_rd_start = 1'b1; i_wr_start = 1'($urandom); i_fetch = 1'($urandom);
        i_addr = DW'($urandom); i_wdata = DW'($urandom);
        if (!o_mem_req) i_mem_ack = 1'b1;
      end else begin
        i_rd_start = 1'b0; i_wr_start = 1'b0;
      end
      step();
    end
    i_rd_start = 1'b0; i_wr_start = 1'b0; i_mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [43:0] outs;
    rst_n = 1'b0;
    step(); step();
    outs = {o_busy, o_done, o_rdata, o_pc_count_en, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_err};
    total++; if (outs !== 44'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    #2 rst_n = 1'b1;
    step();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_read();
    do_txn(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 2, 1'b0);
    exp_rdata = 8'hA5;
    total++; if (obs_first_req !== 0) begin bad++; $display("FAIL read_req_latency got=%0d want=0", obs_first_req); end
    total++; if (obs_req !== 2) begin bad++; $display("FAIL read_req_cycles got=%0d want=2", obs_req); end
    total++; if (obs_we !== 1'b0 || obs_addr !== 8'h3C) begin bad++; $display("FAIL read_bus got=we%b/%h want=we0/3c", obs_we, obs_addr); end
    total++; if (obs_done !== 1 || obs_done_cyc !== 2) begin bad++; $display("FAIL read_done got=%0d@%0d want=1@2", obs_done, obs_done_cyc); end
    total++; if (obs_pc !== 0) begin bad++; $display("FAIL read_pc_en got=%0d want=0", obs_pc); end
    total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL read_rdata got=%h want=%h", o_rdata, exp_rdata); end
  endtask

  task automatic test_fetch();
    do_txn(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'h7E, 1, 1'b0);
    exp_rdata = 8'h7E;
    total++; if (obs_done !== 1 || obs_done_cyc !== 1) begin bad++; $display("FAIL fetch_done got=%0d@%0d want=1@1", obs_done, obs_done_cyc); end
    total++; if (obs_pc !== 1) begin bad++; $display("FAIL fetch_pc_en got=%0d want=1", obs_pc); end
    total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", o_rdata, exp_rdata); end
  endtask

  task automatic test_write_priority();
    int extra_busy = 0;
    do_txn(1'b1, 1'b1, 1'b1, 8'h20, 8'h5A, 8'hC3, 1, 1'b0);
    total++; if (obs_we !== 1'b1 || obs_wdata !== 8'h5A || obs_addr !== 8'h20) begin
      bad++; $display("FAIL write_bus got=we%b/%h/%h want=we1/20/5a", obs_we, obs_addr, obs_wdata); end
    total++; if (obs_req !== 1 || obs_done !== 1) begin bad++; $display("FAIL write_handshake got=req%0d/done%0d want=1/1", obs_req, obs_done); end
    total++; if (obs_pc !== 0) begin bad++; $display("FAIL write_pc_en got=%0d want=0", obs_pc); end
    total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL write_rdata_kept got=%h want=%h", o_rdata, exp_rdata); end
    for (int c = 0; c < 4; c++) begin
      if (o_busy) extra_busy++;
      step();
    end
    total++; if (extra_busy !== 0) begin bad++; $display("FAIL write_single_txn got=%0d want=0", extra_busy); end
  endtask

  task automatic test_ignore_starts();
    do_txn(1'b1, 1'b0, 1'b0, 8'h44, 8'h00, 8'h99, 4, 1'b1);
    exp_rdata = 8'h99;
    total++; if (obs_busy !== 5 || obs_req !== 4) begin bad++; $display("FAIL ignore_busy got=busy%0d/req%0d want=5/4", obs_busy, obs_req); end
    total++; if (obs_unstable !== 1'b0 || obs_addr !== 8'h44 || obs_we !== 1'b0) begin
      bad++; $display("FAIL ignore_bus_stable got=%b/%h/%b want=0/44/0", obs_unstable, obs_addr, obs_we); end
    total++; if (obs_done !== 1 || o_rdata !== exp_rdata) begin bad++; $display("FAIL ignore_done got=%0d/%h want=1/%h", obs_done, o_rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    int e1;
    do_txn(1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h11, 1, 1'b0);
    e1 = obs_start_edge;
    do_txn(1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 8'h22, 1, 1'b0);
    exp_rdata = 8'h22;
    total++; if (obs_start_edge - e1 !== 3) begin bad++; $display("FAIL b2b_spacing got=%0d want=3", obs_start_edge - e1); end
    total++; if (obs_done !== 1 || obs_pc !== 1 || o_rdata !== exp_rdata) begin
      bad++; $display("FAIL b2b_second got=%0d/%0d/%h want=1/1/%h", obs_done, obs_pc, o_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    i_rd_start = 1'b1; i_addr = 8'h55;
    step();
    i_rd_start = 1'b0;
    step();
    total++; if (o_mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_in_access got=%b want=1", o_mem_req); end
    #2 rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    total++; if (o_mem_req !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_async got=req%b/busy%b want=0/0", o_mem_req, o_busy); end
    total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL rstmid_rdata got=%h want=%h", o_rdata, exp_rdata); end
    i_mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_done) done_seen++;
    end
    i_mem_ack = 1'b0;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_done) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_seen); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_txn(1'b1, 1'b0, 1'b1, 8'h66, 8'h00, 8'hEE, 0, 1'b0);
    total++; if (obs_req !== TO || obs_done_cyc !== TO) begin bad++; $display("FAIL timeout_cycles got=%0d@%0d want=%0d", obs_req, obs_done_cyc, TO); end
    total++; if (obs_err !== 1 || obs_done !== 1) begin bad++; $display("FAIL timeout_pulse got=err%0d/done%0d want=1/1", obs_err, obs_done); end
    total++; if (obs_pc !== 0 || o_rdata !== exp_rdata) begin bad++; $display("FAIL timeout_side got=%0d/%h want=0/%h", obs_pc, o_rdata, exp_rdata); end
    do_txn(1'b1, 1'b0, 1'b1, 8'h67, 8'h00, 8'hDB, TO, 1'b0);
    exp_rdata = 8'hDB;
    total++; if (obs_err !== 0 || obs_pc !== 1 || o_rdata !== exp_rdata) begin
      bad++; $display("FAIL timeout_ack_prio got=%0d/%0d/%h want=0/1/%h", obs_err, obs_pc, o_rdata, exp_rdata); end
  endtask
`else
  task automatic test_no_timeout();
    do_txn(1'b1, 1'b0, 1'b0, 8'h66, 8'h00, 8'h3D, 25, 1'b0);
    exp_rdata = 8'h3D;
    total++; if (obs_req !== 25 || obs_done !== 1) begin bad++; $display("FAIL notimeout_wait got=req%0d/done%0d want=25/1", obs_req, obs_done); end
    total++; if (obs_err !== 0 || o_rdata !== exp_rdata) begin bad++; $display("FAIL notimeout_err got=%0d/%h want=0/%h", obs_err, o_rdata, exp_rdata); end
  endtask
`endif

  task automatic test_random();
    logic          rd, wr, fet;
    logic [DW-1:0] addr, wdata, rdata;
    int            k;
    bit            noisy;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom); wr = 1'($urandom); fet = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      addr = DW'($urandom); wdata = DW'($urandom); rdata = DW'($urandom);
      k = $urandom_range(1, 6); noisy = 1'($urandom);
      do_txn(rd, wr, fet, addr, wdata, rdata, k, noisy);
      if (!wr) exp_rdata = rdata;
      total++;
      if (obs_req !== k || obs_done !== 1 || obs_done_cyc !== k || obs_err !== 0 || obs_unstable !== 1'b0) begin
        bad++; $display("FAIL rand%0d_handshake got=req%0d done%0d@%0d err%0d unst%b want=req%0d done1@%0d err0 unst0",
                        n, obs_req, obs_done, obs_done_cyc, obs_err, obs_unstable, k, k);
      end
      total++;
      if (obs_we !== wr || obs_addr !== addr || (wr && obs_wdata !== wdata)) begin
        bad++; $display("FAIL rand%0d_bus got=we%b/%h/%h want=we%b/%h/%h", n, obs_we, obs_addr, obs_wdata, wr, addr, wdata);
      end
      total++;
      if (obs_pc !== int'(fet & ~wr) || o_rdata !== exp_rdata) begin
        bad++; $display("FAIL rand%0d_result got=pc%0d/%h want=pc%0d/%h", n, obs_pc, o_rdata, fet & ~wr, exp_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_fetch();
    test_write_priority();
    test_ignore_starts();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
